code_lock_fsm: RTL and testbench

Code-entry controller for the lock. Sits directly downstream of the decimal digit counter: samples the counter's current value on each confirm pulse, compares the entered sequence against a stored code, and drives the unlock output. On each confirm it issues a one-cycle clear back to the digit counter so every digit starts from 0. Repeated wrong codes can trigger a timed lockout with an alarm.

---
 rtl/code_lock_pkg.sv | 20 ++
 rtl/code_lock_timer.sv | 33 +++
 rtl/code_lock_fsm.sv | 165 ++++++++++++++++
 tb/tb_code_lock_fsm.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// rtl/code_lock_pkg.sv - shared constants and state encoding for the code lock
// Purpose: state encoding for code_lock_fsm, the digit width shared with the
//          decimal digit counter, and a small compile-time helper.
// Ports:   none (package).
package code_lock_pkg;

  // Digit width shared by the digit counter and the code-entry controller.
  localparam int DIGIT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/code_lock_timer.sv
// rtl/code_lock_timer.sv - loadable down-counter with a done flag
// Purpose: one timer shared by the OPEN and LOCKOUT states. Loading N-1
//          makes done rise after N further clock edges.
// Ports:   clk      - rising-edge clock
//          clr_n    - synchronous reset, active-low
//          load     - load load_val this cycle (wins over counting)
//          load_val - value to load
//          done     - counter is at zero
module code_lock_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// rtl/code_lock_fsm.sv - code-entry controller for the lock
// Purpose: samples the digit counter on each enter pulse, checks the entered
//          sequence against the stored code, opens the lock for a fixed time
//          and, with CODE_LOCK_LOCKOUT_EN defined, locks out with an alarm
//          after MAX_FAIL consecutive wrong codes.
// Ports:   clk, clr_n (sync active-low reset), digit, enter, cancel, code
//          (first digit in MSB field) in; dig_clr, pos, unlocked, alarm,
//          fail_cnt out. All outputs registered.
// Macro:   CODE_LOCK_LOCKOUT_EN - builds fail counting and the LOCKOUT state.
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int WIDTH          = DIGIT_WIDTH,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           clr_n,
  input  logic [WIDTH-1:0]               digit,
  input  logic                           enter,
  input  logic                           cancel,
  input  logic [DIGITS*WIDTH-1:0]        code,
  output logic                           dig_clr,
  output logic [$clog2(DIGITS+1)-1:0]    pos,
  output logic                           unlocked,
  output logic                           alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt
);

  localparam int PW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);

  localparam logic [PW-1:0] LAST_POS  = PW'(DIGITS - 1);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(UNLOCK_CYCLES - 1);

  state_t            state, state_n;
  logic [PW-1:0]     pos_n;
  logic              mm_q, mm_n, mm_now;
  logic              dig_clr_n;
  logic              tmr_load, tmr_done;
  logic [TW-1:0]     tmr_val;
  logic [DIGITS*WIDTH-1:0] code_sh;
  logic [WIDTH-1:0]  exp_digit;

`ifdef CODE_LOCK_LOCKOUT_EN
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
  logic [FW-1:0] fail_q, fail_n;
  logic          alarm_q;
`endif

  // Bring the field for the current position down to the low bits.
  assign code_sh   = code >> (WIDTH * (DIGITS - 1 - int'(pos)));
  assign exp_digit = code_sh[WIDTH-1:0];

  code_lock_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_n   = state;
    pos_n     = pos;
    mm_n      = mm_q;
    dig_clr_n = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
`ifdef CODE_LOCK_LOCKOUT_EN
    fail_n    = fail_q;
`endif
    // Final verdict must include the digit being entered right now.
    mm_now    = mm_q | (digit != exp_digit);

    case (state)
      ST_ENTRY: begin
        if (cancel) begin
          pos_n     = '0;
          mm_n      = 1'b0;
          dig_clr_n = 1'b1;
        end else if (enter) begin
          dig_clr_n = 1'b1;
          if (pos == LAST_POS) begin
            pos_n = '0;
            mm_n  = 1'b0;
            if (!mm_now) begin
              state_n  = ST_OPEN;
              tmr_load = 1'b1;
              tmr_val  = OPEN_LOAD;
`ifdef CODE_LOCK_LOCKOUT_EN
              fail_n   = '0;
`endif
            end else begin
`ifdef CODE_LOCK_LOCKOUT_EN
              if (fail_q == FAIL_MAX - 1'b1) begin
                fail_n   = FAIL_MAX;
                state_n  = ST_LOCKOUT;
                tmr_load = 1'b1;
                tmr_val  = LOCK_LOAD;
              end else begin
                fail_n = fail_q + 1'b1;
              end
`endif
            end
          end else begin
            pos_n = pos + 1'b1;
            mm_n  = mm_now;
          end
        end
      end
      ST_OPEN: begin
        if (cancel || tmr_done) state_n = ST_ENTRY;
      end
      default: begin
`ifdef CODE_LOCK_LOCKOUT_EN
        if (tmr_done) begin
          state_n = ST_ENTRY;
          fail_n  = '0;
        end
`else
        state_n = ST_ENTRY;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state    <= ST_ENTRY;
      pos      <= '0;
      mm_q     <= 1'b0;
      dig_clr  <= 1'b0;
      unlocked <= 1'b0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      mm_q     <= mm_n;
      dig_clr  <= dig_clr_n;
      unlocked <= (state_n == ST_OPEN);
    end
  end

`ifdef CODE_LOCK_LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      fail_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      fail_q  <= fail_n;
      alarm_q <= (state_n == ST_LOCKOUT);
    end
  end
  assign fail_cnt = fail_q;
  assign alarm    = alarm_q;
`else
  assign fail_cnt = '0;
  assign alarm    = 1'b0;
`endif

endmodule

// File: tb/tb_code_lock_fsm.sv
// tb/tb_code_lock_fsm.sv - self-checking bench for code_lock_fsm
module tb_code_lock_fsm;

`ifdef CODE_LOCK_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr_n;
    logic [3:0]  digit;
    logic        enter;
    logic        cancel;
    logic [15:0] code;
    logic        dig_clr;
    logic [2:0]  pos;
    logic        unlocked;
    logic        alarm;
    logic [1:0]  fail_cnt;

    always #5 clk = ~clk;

    code_lock_fsm dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .digit    (digit),
        .enter    (enter),
        .cancel   (cancel),
        .code     (code),
        .dig_clr  (dig_clr),
        .pos      (pos),
        .unlocked (unlocked),
        .alarm    (alarm),
        .fail_cnt (fail_cnt)
    );

    typedef struct {
        logic [3:0] digit;
        logic       enter;
        logic       cancel;
        logic       clr_n;
        logic [2:0] pos;
        logic       dig_clr;
        logic       unlocked;
        logic       alarm;
        logic [1:0] fail;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   run_done = 1'b0;

    function automatic int fx(input int x);
        return LOCK_EN ? x : 0;
    endfunction

    function automatic void v(input int d, input bit en, input bit ca, input bit rn,
                              input int p, input bit dc, input bit u, input bit a, input int f);
        vec_t t;
        t.digit = 4'(d); t.enter = en; t.cancel = ca; t.clr_n = rn;
        t.pos = 3'(p); t.dig_clr = dc; t.unlocked = u; t.alarm = a; t.fail = 2'(f);
        vecs.push_back(t);
    endfunction

    function automatic void idle(input int n, input bit u, input bit a, input int f);
        for (int i = 0; i < n; i++) v(0, 0, 0, 1, 0, 0, u, a, f);
    endfunction

    function automatic void enter_code(input logic [15:0] c, input bit ok, input bit alm,
                                       input int fb, input int fa);
        logic [15:0] cc;
        cc = c;
        for (int i = 0; i < 3; i++) v(int'(cc[15-4*i -: 4]), 1, 0, 1, i + 1, 1, 0, 0, fb);
        v(int'(cc[3:0]), 1, 0, 1, 0, 1, ok, alm, fa);
    endfunction

    initial begin
        #1000000;
        if (!run_done) begin
            errors++;
            $display("FAIL timeout waiting for vector run to complete");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        vec_t e;
        logic [7:0] got, want;

        clr_n = 1'b0; digit = '0; enter = 1'b0; cancel = 1'b0; code = 16'h1234;

        v(0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(5, 1, 1, 0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 1, 1, 1, 0, 0, 0);
        v(1, 0, 0, 1, 1, 0, 0, 0, 0);
        v(2, 1, 0, 1, 2, 1, 0, 0, 0);
        v(3, 1, 0, 1, 3, 1, 0, 0, 0);
        v(4, 1, 0, 1, 0, 1, 1, 0, 0);
        v(1, 1, 0, 1, 0, 0, 1, 0, 0);
        idle(6, 1, 0, 0);
        idle(1, 0, 0, 0);
        enter_code(16'h1235, 0, 0, 0, fx(1));
        idle(1, 0, 0, fx(1));
        enter_code(16'h1234, 1, 0, fx(1), 0);
        idle(7, 1, 0, 0);
        idle(1, 0, 0, 0);
        enter_code(16'h1235, 0, 0, 0, fx(1));
        v(1, 1, 0, 1, 1, 1, 0, 0, fx(1));
        v(2, 1, 0, 1, 2, 1, 0, 0, fx(1));
        v(3, 1, 1, 1, 0, 1, 0, 0, fx(1));
        v(9, 1, 0, 1, 1, 1, 0, 0, fx(1));
        v(0, 0, 1, 1, 0, 1, 0, 0, fx(1));
        enter_code(16'h1234, 1, 0, fx(1), 0);
        idle(7, 1, 0, 0);
        idle(1, 0, 0, 0);
        enter_code(16'h1234, 1, 0, 0, 0);
        idle(1, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3, 0, 0, 0);
        v(1, 1, 0, 1, 1, 1, 0, 0, 0);
        v(2, 1, 0, 1, 2, 1, 0, 0, 0);
        v(3, 1, 0, 0, 0, 0, 0, 0, 0);
        enter_code(16'h1234, 1, 0, 0, 0);
        idle(1, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0, 0, 0, 0);
        idle(2, 0, 0, 0);
        if (LOCK_EN) begin
            enter_code(16'h1235, 0, 0, 0, 1);
            enter_code(16'h0000, 0, 0, 1, 2);
            enter_code(16'h4321, 0, 1, 2, 3);
            for (int i = 0; i < 15; i++) v(1, (i % 2) == 0, i == 5, 1, 0, 0, 0, 1, 3);
            idle(1, 0, 0, 0);
        end else begin
            for (int k = 0; k < 5; k++) enter_code(16'h1235 + 16'(k), 0, 0, 0, 0);
        end
        enter_code(16'h1234, 1, 0, 0, 0);
        idle(7, 1, 0, 0);
        idle(1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            digit  = vecs[i].digit;
            enter  = vecs[i].enter;
            cancel = vecs[i].cancel;
            clr_n  = vecs[i].clr_n;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            got  = {pos, dig_clr, unlocked, alarm, fail_cnt};
            want = {e.pos, e.dig_clr, e.unlocked, e.alarm, e.fail};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL vec%0d pos/dig_clr/unlocked/alarm/fail_cnt got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                         i, pos, dig_clr, unlocked, alarm, fail_cnt,
                         e.pos, e.dig_clr, e.unlocked, e.alarm, e.fail);
            end
            if (!e.clr_n) begin
                checks++;
                if ({pos, dig_clr, unlocked, alarm, fail_cnt} !== 8'd0) begin
                    errors++;
                    $display("FAIL vec%0d reset state not clean: pos=%0d dig_clr=%0d unlocked=%0d alarm=%0d fail_cnt=%0d",
                             i, pos, dig_clr, unlocked, alarm, fail_cnt);
                end
            end
        end

        run_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
